// File: rtl/bfp_scheduler.sv
// bfp_scheduler: time-shares one combinational body-fat-percentage unit
// between a female and a male request channel. A round-robin arbiter picks
// a channel, its operands are registered onto the bfp inputs, the unit is
// given a fixed settle time, and the captured range is returned over a
// valid/ready result port tagged with the channel that produced it.
module bfp_scheduler #(
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    // female request channel
    input  logic             f_req,
    input  logic [7:0]       f_w,
    input  logic [7:0]       f_h,
    input  logic [7:0]       f_a,
    output logic             f_ack,
    // male request channel
    input  logic             m_req,
    input  logic [7:0]       m_w,
    input  logic [7:0]       m_h,
    input  logic [7:0]       m_a,
    output logic             m_ack,
    // drive to the shared bfp unit
    output logic [7:0]       bfp_wf,
    output logic [7:0]       bfp_hf,
    output logic [7:0]       bfp_af,
    output logic [7:0]       bfp_wm,
    output logic [7:0]       bfp_hm,
    output logic [7:0]       bfp_am,
    output logic             bfp_s,
    input  logic [7:0]       bfp_range,
    // result port
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_range,
    output logic             res_sex,
    // status
    output logic             busy,
    output logic [CNT_W-1:0] served_cnt
);

    // A settle time below one cycle makes no sense; clamp it.
    localparam int SETTLE_EFF = (SETTLE_CYC < 1) ? 1 : SETTLE_CYC;
    // The timer only ever holds SETTLE_EFF-1 down to 0.
    localparam int TMR_W      = (SETTLE_EFF <= 1) ? 1 : $clog2(SETTLE_EFF);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_e;

    localparam logic SEX_F = 1'b0;
    localparam logic SEX_M = 1'b1;

    state_e           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             last_grant_q, last_grant_d;
    logic             f_ack_q, f_ack_d;
    logic             m_ack_q, m_ack_d;
    logic [7:0]       wf_q, wf_d, hf_q, hf_d, af_q, af_d;
    logic [7:0]       wm_q, wm_d, hm_q, hm_d, am_q, am_d;
    logic             s_q, s_d;
    logic             res_valid_q, res_valid_d;
    logic [7:0]       res_range_q, res_range_d;
    logic             res_sex_q, res_sex_d;
    logic [CNT_W-1:0] served_q, served_d;

    // Round-robin pick: a lone requester wins; on a tie the channel that
    // was not served last wins.
    logic grant_m;
    assign grant_m = m_req & (~f_req | (last_grant_q == SEX_F));

    // Next-state and datapath decode for the IDLE/SETTLE/HOLD sequencer.
    always_comb begin
        // NOTE: every variable gets its hold/default value first so no path
        // through the case leaves one unassigned, which would infer a latch.
        state_d      = state_q;
        tmr_d        = tmr_q;
        last_grant_d = last_grant_q;
        f_ack_d      = 1'b0;
        m_ack_d      = 1'b0;
        wf_d         = wf_q;
        hf_d         = hf_q;
        af_d         = af_q;
        wm_d         = wm_q;
        hm_d         = hm_q;
        am_d         = am_q;
        s_d          = s_q;
        res_valid_d  = res_valid_q;
        res_range_d  = res_range_q;
        res_sex_d    = res_sex_q;
        served_d     = served_q;

        unique case (state_q)
            IDLE: begin
                if (f_req || m_req) begin
                    if (grant_m) begin
                        // only the granted side's operand registers move
                        wm_d    = m_w;
                        hm_d    = m_h;
                        am_d    = m_a;
                        m_ack_d = 1'b1;
                    end else begin
                        wf_d    = f_w;
                        hf_d    = f_h;
                        af_d    = f_a;
                        f_ack_d = 1'b1;
                    end
                    s_d          = grant_m;
                    last_grant_d = grant_m;
                    tmr_d        = TMR_W'(SETTLE_EFF - 1);
                    state_d      = SETTLE;
                end
            end

            SETTLE: begin
                // bfp_range is only looked at on this one edge
                if (tmr_q == '0) begin
                    res_range_d = bfp_range;
                    res_sex_d   = s_q;
                    res_valid_d = 1'b1;
                    state_d     = HOLD;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end

            HOLD: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    served_d    = served_q + 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset returns everything to zero with
    // the male channel marked as last served so female wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            tmr_q        <= '0;
            last_grant_q <= SEX_M;
            f_ack_q      <= 1'b0;
            m_ack_q      <= 1'b0;
            wf_q         <= '0;
            hf_q         <= '0;
            af_q         <= '0;
            wm_q         <= '0;
            hm_q         <= '0;
            am_q         <= '0;
            s_q          <= 1'b0;
            res_valid_q  <= 1'b0;
            res_range_q  <= '0;
            res_sex_q    <= 1'b0;
            served_q     <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge
            // values computed above, independent of statement order.
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            last_grant_q <= last_grant_d;
            f_ack_q      <= f_ack_d;
            m_ack_q      <= m_ack_d;
            wf_q         <= wf_d;
            hf_q         <= hf_d;
            af_q         <= af_d;
            wm_q         <= wm_d;
            hm_q         <= hm_d;
            am_q         <= am_d;
            s_q          <= s_d;
            res_valid_q  <= res_valid_d;
            res_range_q  <= res_range_d;
            res_sex_q    <= res_sex_d;
            served_q     <= served_d;
        end
    end

    assign f_ack      = f_ack_q;
    assign m_ack      = m_ack_q;
    assign bfp_wf     = wf_q;
    assign bfp_hf     = hf_q;
    assign bfp_af     = af_q;
    assign bfp_wm     = wm_q;
    assign bfp_hm     = hm_q;
    assign bfp_am     = am_q;
    assign bfp_s      = s_q;
    assign res_valid  = res_valid_q;
    assign res_range  = res_range_q;
    assign res_sex    = res_sex_q;
    assign served_cnt = served_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_bfp_scheduler.sv
// Self-checking bench for bfp_scheduler. A transaction-level model (grant
// choice, settle age, pending result, served count) predicts every output
// each cycle; directed scenarios add pinned values on top.
module tb_bfp_scheduler;

    localparam int SETTLE = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // main instance (SETTLE_CYC = 2)
    logic       f_req, m_req, f_ack, m_ack;
    logic [7:0] f_w, f_h, f_a, m_w, m_h, m_a;
    logic [7:0] bfp_wf, bfp_hf, bfp_af, bfp_wm, bfp_hm, bfp_am, bfp_range;
    logic       bfp_s, res_valid, res_ready, res_sex, busy;
    logic [7:0] res_range, served_cnt;

    // second instance (SETTLE_CYC = 4), used for the settle-time test
    logic       f_req4, m_req4, f_ack4, m_ack4;
    logic [7:0] f_w4, f_h4, f_a4, m_w4, m_h4, m_a4;
    logic [7:0] wf4, hf4, af4, wm4, hm4, am4, bfp_range4;
    logic       s4, res_valid4, res_ready4, res_sex4, busy4;
    logic [7:0] res_range4, served_cnt4;

    // Behavioural stand-in for the bfp unit.
    function automatic logic [7:0] bfp_model(input logic s, input logic [7:0] w,
                                             input logic [7:0] h, input logic [7:0] a);
        logic [7:0] base;
        base = (w >> 2) + (a >> 3) + (h >> 7);
        return s ? base - 8'd6 : base + 8'd4;
    endfunction

    assign bfp_range = bfp_model(bfp_s, bfp_s ? bfp_wm : bfp_wf,
                                 bfp_s ? bfp_hm : bfp_hf, bfp_s ? bfp_am : bfp_af);

    bfp_scheduler #(.SETTLE_CYC(SETTLE), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_w(f_w), .f_h(f_h), .f_a(f_a), .f_ack(f_ack),
        .m_req(m_req), .m_w(m_w), .m_h(m_h), .m_a(m_a), .m_ack(m_ack),
        .bfp_wf(bfp_wf), .bfp_hf(bfp_hf), .bfp_af(bfp_af),
        .bfp_wm(bfp_wm), .bfp_hm(bfp_hm), .bfp_am(bfp_am),
        .bfp_s(bfp_s), .bfp_range(bfp_range),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_range(res_range), .res_sex(res_sex),
        .busy(busy), .served_cnt(served_cnt)
    );

    bfp_scheduler #(.SETTLE_CYC(4), .CNT_W(8)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req4), .f_w(f_w4), .f_h(f_h4), .f_a(f_a4), .f_ack(f_ack4),
        .m_req(m_req4), .m_w(m_w4), .m_h(m_h4), .m_a(m_a4), .m_ack(m_ack4),
        .bfp_wf(wf4), .bfp_hf(hf4), .bfp_af(af4),
        .bfp_wm(wm4), .bfp_hm(hm4), .bfp_am(am4),
        .bfp_s(s4), .bfp_range(bfp_range4),
        .res_valid(res_valid4), .res_ready(res_ready4),
        .res_range(res_range4), .res_sex(res_sex4),
        .busy(busy4), .served_cnt(served_cnt4)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    logic       mdl_busy, mdl_valid, mdl_sex, mdl_last;
    int         mdl_age;
    logic [7:0] mdl_op [6];   // wf hf af wm hm am
    logic [7:0] mdl_range, mdl_served;
    logic       exp_f_ack, exp_m_ack;

    task automatic model_reset();
        mdl_busy = 1'b0; mdl_valid = 1'b0; mdl_sex = 1'b0; mdl_last = 1'b1;
        mdl_age = 0; mdl_range = '0; mdl_served = '0;
        exp_f_ack = 1'b0; exp_m_ack = 1'b0;
        for (int i = 0; i < 6; i++) mdl_op[i] = '0;
    endtask

    // What one rising edge does, given the inputs presented to it.
    task automatic model_edge();
        logic pick_m;
        exp_f_ack = 1'b0;
        exp_m_ack = 1'b0;
        if (!mdl_busy) begin
            if (f_req || m_req) begin
                pick_m = (f_req && m_req) ? !mdl_last : m_req;
                if (pick_m) begin
                    mdl_op[3] = m_w; mdl_op[4] = m_h; mdl_op[5] = m_a; exp_m_ack = 1'b1;
                end else begin
                    mdl_op[0] = f_w; mdl_op[1] = f_h; mdl_op[2] = f_a; exp_f_ack = 1'b1;
                end
                mdl_sex = pick_m; mdl_last = pick_m; mdl_busy = 1'b1; mdl_age = 0;
            end
        end else if (!mdl_valid) begin
            mdl_age++;
            if (mdl_age == SETTLE) begin
                mdl_valid = 1'b1;
                mdl_range = mdl_sex ? bfp_model(1'b1, mdl_op[3], mdl_op[4], mdl_op[5])
                                    : bfp_model(1'b0, mdl_op[0], mdl_op[1], mdl_op[2]);
            end
        end else if (res_ready) begin
            mdl_valid = 1'b0; mdl_busy = 1'b0; mdl_served = mdl_served + 8'd1;
        end
    endtask

    task automatic check_all();
        check("f_ack", f_ack, exp_f_ack);
        check("m_ack", m_ack, exp_m_ack);
        check("bfp_wf", bfp_wf, mdl_op[0]);
        check("bfp_hf", bfp_hf, mdl_op[1]);
        check("bfp_af", bfp_af, mdl_op[2]);
        check("bfp_wm", bfp_wm, mdl_op[3]);
        check("bfp_hm", bfp_hm, mdl_op[4]);
        check("bfp_am", bfp_am, mdl_op[5]);
        check("bfp_s", bfp_s, mdl_sex);
        check("res_valid", res_valid, mdl_valid);
        check("busy", busy, mdl_busy);
        check("served_cnt", served_cnt, mdl_served);
        if (mdl_valid) begin
            check("res_range", res_range, mdl_range);
            check("res_sex", res_sex, mdl_sex);
        end
    endtask

    int n_res, n_res_f, n_res_m, n_fack, n_mack;

    // One clock: edge, model update, sample on the falling edge, and the
    // requester drops req after being acknowledged.
    task automatic step();
        if (res_valid && res_ready) begin
            n_res++;
            if (res_sex) n_res_m++; else n_res_f++;
        end
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        check_all();
        if (f_ack) n_fack++;
        if (m_ack) n_mack++;
        if (exp_f_ack) f_req = 1'b0;
        if (exp_m_ack) m_req = 1'b0;
    endtask

    // Asynchronous reset pulse between clock edges.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int guard;
        res_ready = 1'b1;
        guard = 0;
        while ((mdl_busy || f_req || m_req) && guard < 100) begin
            step();
            guard++;
        end
        check("drain_timeout", guard < 100, 1'b1);
    endtask

    task automatic set_f(input logic [7:0] w, input logic [7:0] h, input logic [7:0] a);
        f_req = 1'b1; f_w = w; f_h = h; f_a = a;
    endtask

    task automatic set_m(input logic [7:0] w, input logic [7:0] h, input logic [7:0] a);
        m_req = 1'b1; m_w = w; m_h = h; m_a = a;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        f_req = 0; m_req = 0; f_w = 0; f_h = 0; f_a = 0; m_w = 0; m_h = 0; m_a = 0;
        res_ready = 0;
        f_req4 = 0; m_req4 = 0; f_w4 = 0; f_h4 = 0; f_a4 = 0;
        m_w4 = 0; m_h4 = 0; m_a4 = 0; bfp_range4 = 0; res_ready4 = 0;
        n_res = 0; n_res_f = 0; n_res_m = 0; n_fack = 0; n_mack = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // ---- single female transaction ----
        set_f(8'h50, 8'hAA, 8'h18);
        res_ready = 1'b1;
        step();
        check("t1_f_ack", f_ack, 1'b1);
        check("t1_wf", bfp_wf, 8'h50);
        step();
        check("t1_valid_early", res_valid, 1'b0);
        step();
        check("t1_valid", res_valid, 1'b1);
        check("t1_range", res_range, 8'h1C);
        step();
        check("t1_served", served_cnt, 8'd1);

        // ---- simultaneous requests alternate, female first after reset ----
        do_reset();
        set_f(8'h50, 8'hAA, 8'h18);
        set_m(8'h50, 8'hAA, 8'h18);
        step();
        check("t2_first_f", f_ack, 1'b1);
        step(); step();
        check("t2_f_range", res_range, 8'h1C);
        check("t2_f_sex", res_sex, 1'b0);
        step(); step();
        check("t2_then_m", m_ack, 1'b1);
        check("t2_bfp_s", bfp_s, 1'b1);
        step(); step();
        check("t2_m_range", res_range, 8'h12);
        check("t2_m_sex", res_sex, 1'b1);
        step();
        set_f(8'h33, 8'h90, 8'h40);
        set_m(8'h61, 8'h20, 8'h11);
        step();
        check("t2_third_f", f_ack, 1'b1);
        check("t2_third_no_m", m_ack, 1'b0);
        drain();

        // ---- back-pressure holds the result; waiting request gets no ack ----
        res_ready = 1'b0;
        set_f(8'h7E, 8'h55, 8'h2A);
        repeat (3) step();
        for (int i = 0; i < 10; i++) begin
            if (i == 2) set_m(8'h44, 8'h88, 8'h22);
            step();
            check("bp_busy", busy, 1'b1);
        end
        res_ready = 1'b1;
        step();
        check("bp_no_m_ack_yet", m_ack, 1'b0);
        step();
        check("bp_m_ack", m_ack, 1'b1);
        drain();

        // ---- SETTLE_CYC=4: range changes during settle, final value captured ----
        f_req4 = 1'b1; f_w4 = 8'h12; f_h4 = 8'h34; f_a4 = 8'h56; bfp_range4 = 8'h05;
        @(posedge clk); @(negedge clk);
        check("s4_ack", f_ack4, 1'b1);
        f_req4 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); @(negedge clk);
            check("s4_valid", res_valid4, (k == 4));
            if (k == 2) bfp_range4 = 8'h09;
        end
        check("s4_range", res_range4, 8'h09);
        check("s4_sex", res_sex4, 1'b0);
        bfp_range4 = 8'hEE;
        res_ready4 = 1'b1;
        @(posedge clk); @(negedge clk);
        check("s4_accept", res_valid4, 1'b0);
        check("s4_served", served_cnt4, 8'd1);
        check("s4_range_hold", res_range4, 8'h09);
        res_ready4 = 1'b0;

        // ---- reset during SETTLE with m_req held ----
        set_f(8'h21, 8'h43, 8'h65);
        res_ready = 1'b1;
        step();
        set_m(8'h10, 8'h20, 8'h30);
        step();
        do_reset();
        check("rst_served", served_cnt, 8'd0);
        check("rst_valid", res_valid, 1'b0);
        step();
        check("rst_m_ack", m_ack, 1'b1);
        drain();

        // ---- 256 back-to-back transactions with both channels requesting ----
        do_reset();
        n_res = 0; n_res_f = 0; n_res_m = 0; n_fack = 0; n_mack = 0;
        res_ready = 1'b1;
        guard = 0;
        while (n_res < 256 && guard < 2000) begin
            if (!f_req && !exp_f_ack) set_f(8'($urandom), 8'($urandom), 8'($urandom));
            if (!m_req && !exp_m_ack) set_m(8'($urandom), 8'($urandom), 8'($urandom));
            step();
            guard++;
        end
        check("wrap_timeout", guard < 2000, 1'b1);
        check("wrap_served", served_cnt, 8'd0);
        check("wrap_results", n_res, 256);
        check("wrap_acks", n_fack + n_mack, 256);
        check("wrap_f_acks", n_fack, 128);
        check("wrap_m_results", n_res_m, 128);
        drain();

        // ---- randomized traffic and back-pressure ----
        for (int i = 0; i < 600; i++) begin
            if (!f_req && !exp_f_ack && ($urandom_range(0, 3) == 0))
                set_f(8'($urandom), 8'($urandom), 8'($urandom));
            if (!m_req && !exp_m_ack && ($urandom_range(0, 3) == 0))
                set_m(8'($urandom), 8'($urandom), 8'($urandom));
            res_ready = ($urandom_range(0, 9) < 6);
            step();
        end
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
